// File: rtl/snoop_responder.sv
// Coherence snoop responder: MSI lookup of local dcache frames, dirty-block supply
// over the data port, and M->S / ->I state updates through a single-cycle port.
module snoop_responder #(
  parameter int unsigned WAYS = 2,
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ccwait,
  input  logic             ccinv,
  input  logic [31:0]      ccsnoopaddr,
  input  logic             dwait,
  input  logic             cache_idle,
  output logic             ccwrite,
  output logic             dWEN,
  output logic [31:0]      daddr,
  output logic [31:0]      dstore,
  output logic             busy,
  output logic [31:0]      lk_addr,
  input  logic             lk_hit,
  input  logic [WAY_W-1:0] lk_way,
  input  logic             lk_dirty,
  input  logic [31:0]      lk_data0,
  input  logic [31:0]      lk_data1,
  output logic             st_we,
  output logic [WAY_W-1:0] st_way,
  output logic             st_valid,
  output logic             st_dirty
);

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWb0,
    StWb1,
    StUpd,
    StResp
  } state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [31:0]        r_saddr;
  logic               r_sinv;
  logic [WAY_W-1:0]   r_sway;
  logic               r_shit;
  logic               r_sdirty;
  logic [31:0]        r_sdata0;
  logic [31:0]        r_sdata1;
  logic               r_resp_first;
  logic [31:0]        w_base;

  assign lk_addr = r_saddr;
  assign w_base  = {r_saddr[31:3], 3'b000};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= StIdle;
      r_saddr      <= '0;
      r_sinv       <= 1'b0;
      r_sway       <= '0;
      r_shit       <= 1'b0;
      r_sdirty     <= 1'b0;
      r_sdata0     <= '0;
      r_sdata1     <= '0;
      r_resp_first <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      // High only during the first cycle after LOOKUP, i.e. the first RESP cycle.
      r_resp_first <= (r_state == StLookup);
      if (r_state == StIdle && ccwait && cache_idle) begin
        r_saddr <= ccsnoopaddr;
        r_sinv  <= ccinv;
      end
      if (r_state == StLookup) begin
        r_shit   <= lk_hit;
        r_sway   <= lk_way;
        r_sdirty <= lk_dirty;
        r_sdata0 <= lk_data0;
        r_sdata1 <= lk_data1;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    ccwrite   = 1'b0;
    dWEN      = 1'b0;
    daddr     = '0;
    dstore    = '0;
    busy      = 1'b0;
    st_we     = 1'b0;
    st_way    = '0;
    st_valid  = 1'b0;
    st_dirty  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (ccwait && cache_idle) w_state_d = StLookup;
      end
      StLookup: begin
        busy      = 1'b1;
        w_state_d = (lk_hit && lk_dirty) ? StWb0 : StResp;
      end
      StWb0: begin
        busy    = 1'b1;
        ccwrite = 1'b1;
        dWEN    = 1'b1;
        daddr   = w_base;
        dstore  = r_sdata0;
        if (!dwait) w_state_d = StWb1;
      end
      StWb1: begin
        busy    = 1'b1;
        ccwrite = 1'b1;
        dWEN    = 1'b1;
        daddr   = w_base + 32'd4;
        dstore  = r_sdata1;
        if (!dwait) w_state_d = StUpd;
      end
      StUpd: begin
        busy      = 1'b1;
        st_we     = 1'b1;
        st_way    = r_sway;
        st_valid  = !r_sinv;
        w_state_d = StIdle;
      end
      StResp: begin
        busy    = 1'b1;
        ccwrite = 1'b1;
        if (r_resp_first && r_shit && r_sinv) begin
          st_we  = 1'b1;
          st_way = r_sway;
        end
        if (!ccwait) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_snoop_responder.sv
// Bench for snoop_responder: table of snoop scenarios driven through a fixed
// cycle schedule; writeback words and state updates checked against a queue.
module tb_snoop_responder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ccwait, ccinv, dwait, cache_idle;
  logic [31:0] ccsnoopaddr;
  logic        ccwrite, dWEN, busy;
  logic [31:0] daddr, dstore, lk_addr;
  logic        lk_hit, lk_dirty;
  logic [0:0]  lk_way;
  logic [31:0] lk_data0, lk_data1;
  logic        st_we, st_valid, st_dirty;
  logic [0:0]  st_way;

  int n_err = 0;
  int n_chk = 0;

  always #5 CLK = ~CLK;

  snoop_responder #(.WAYS(2)) dut (
    .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .dwait(dwait), .cache_idle(cache_idle), .ccwrite(ccwrite), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .busy(busy), .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_way(lk_way),
    .lk_dirty(lk_dirty), .lk_data0(lk_data0), .lk_data1(lk_data1), .st_we(st_we),
    .st_way(st_way), .st_valid(st_valid), .st_dirty(st_dirty)
  );

  typedef struct {
    logic [31:0] addr;
    logic        inv;
    logic        hit;
    logic [0:0]  way;
    logic        dirty;
    logic [31:0] d0;
    logic [31:0] d1;
    int          w0;
    int          w1;
    int          hold;
    int          idle_dly;
    logic        exp_wb;
    logic [31:0] exp_a0;
    logic [31:0] exp_a1;
    logic        exp_upd;
    logic        exp_valid;
  } vec_t;

  // kind 0: accepted writeback word (a=daddr, b=dstore); kind 1: state update
  // (a=way, b={valid,dirty}).
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  ev_t  q[$];
  ev_t  mon_ev;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (nRST && !dWEN) begin
      n_chk++;
      if (daddr !== 32'h0 || dstore !== 32'h0) begin
        n_err++;
        $display("FAIL idle_bus: daddr=%h dstore=%h expected 0 with dWEN=0", daddr, dstore);
      end
    end
    if (dWEN && !dwait) begin
      n_chk++;
      if (q.size() == 0 || q[0].kind != 0) begin
        n_err++;
        $display("FAIL wb_word: unexpected word daddr=%h dstore=%h", daddr, dstore);
      end else begin
        mon_ev = q.pop_front();
        if (daddr !== mon_ev.a || dstore !== mon_ev.b) begin
          n_err++;
          $display("FAIL wb_word: got %h/%h expected %h/%h", daddr, dstore, mon_ev.a, mon_ev.b);
        end
      end
    end
    if (st_we) begin
      n_chk++;
      if (q.size() == 0 || q[0].kind != 1) begin
        n_err++;
        $display("FAIL st_update: unexpected st_we way=%0d valid=%0b", st_way, st_valid);
      end else begin
        mon_ev = q.pop_front();
        if (32'(st_way) !== mon_ev.a || {30'b0, st_valid, st_dirty} !== mon_ev.b) begin
          n_err++;
          $display("FAIL st_update: got way=%0d v/d=%0b%0b expected way=%0d v/d=%b",
                   st_way, st_valid, st_dirty, mon_ev.a, mon_ev.b[1:0]);
        end
      end
    end
  end

  task automatic run_snoop(input vec_t v);
    lk_hit   = v.hit;
    lk_way   = v.way;
    lk_dirty = v.dirty;
    lk_data0 = v.d0;
    lk_data1 = v.d1;
    if (v.exp_wb) begin
      q.push_back('{kind: 0, a: v.exp_a0, b: v.d0});
      q.push_back('{kind: 0, a: v.exp_a1, b: v.d1});
    end
    if (v.exp_upd) q.push_back('{kind: 1, a: 32'(v.way), b: {30'b0, v.exp_valid, 1'b0}});
    ccwait      = 1'b1;
    ccsnoopaddr = v.addr;
    ccinv       = v.inv;
    cache_idle  = (v.idle_dly == 0);
    for (int i = 0; i < v.idle_dly; i++) begin
      step();
      chk("stall_busy", 32'(busy), 32'd0);
    end
    cache_idle = 1'b1;
    step();
    chk("lookup_busy", 32'(busy), 32'd1);
    chk("lookup_ccwrite", 32'(ccwrite), 32'd0);
    chk("lookup_addr", lk_addr, v.addr);
    ccsnoopaddr = ~v.addr;
    ccinv       = ~v.inv;
    step();
    chk("resp_ccwrite", 32'(ccwrite), 32'd1);
    chk("resp_dwen", 32'(dWEN), 32'(v.exp_wb));
    chk("held_addr", lk_addr, v.addr);
    if (v.exp_wb) begin
      ccwait = 1'b0;
      dwait  = 1'b1;
      repeat (v.w0) step();
      dwait = 1'b0;
      step();
      chk("wb1_dwen", 32'(dWEN), 32'd1);
      dwait = 1'b1;
      repeat (v.w1) step();
      dwait = 1'b0;
      step();
      chk("upd_st_we", 32'(st_we), 32'd1);
      chk("upd_ccwrite", 32'(ccwrite), 32'd0);
      dwait = 1'b1;
      step();
      chk("done_busy", 32'(busy), 32'd0);
    end else begin
      dwait = 1'($urandom_range(0, 1));
      repeat (v.hold) begin
        step();
        chk("hold_ccwrite", 32'(ccwrite), 32'd1);
        chk("hold_no_st", 32'(st_we), 32'd0);
      end
      ccwait = 1'b0;
      step();
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_ccwrite", 32'(ccwrite), 32'd0);
    end
    chk("sb_drained", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    // addr inv hit way dirty d0 d1 w0 w1 hold idle | exp_wb a0 a1 exp_upd exp_valid
    vecs[0] = '{32'h0000_1008, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 1, 0,
                1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_1104, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1111, 32'h2222, 0, 0, 3, 0,
                1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_2044, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 3, 2, 0, 0,
                1'b1, 32'h0000_2040, 32'h0000_2044, 1'b1, 1'b1};
    vecs[3] = '{32'h0000_3010, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 32'h5A5A_0002, 0, 1, 0, 0,
                1'b1, 32'h0000_3010, 32'h0000_3014, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0A0C, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3, 32'h4, 0, 0, 2, 4,
                1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFF8, 1'b1, 1'b0, 1'b1, 1'b1, 32'h5, 32'h6, 0, 0, 0, 0,
                1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_5FFC, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0123_4567, 32'h89AB_CDEF, 1, 0, 0, 2,
                1'b1, 32'h0000_5FF8, 32'h0000_5FFC, 1'b1, 1'b1};

    nRST = 1'b0; ccwait = 1'b0; ccinv = 1'b0; ccsnoopaddr = 32'h0; dwait = 1'b1;
    cache_idle = 1'b1; lk_hit = 1'b0; lk_way = 1'b0; lk_dirty = 1'b0;
    lk_data0 = 32'h0; lk_data1 = 32'h0;
    repeat (2) step();
    chk("rst_ccwrite", 32'(ccwrite), 32'd0);
    chk("rst_dwen", 32'(dWEN), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_st_we", 32'(st_we), 32'd0);
    chk("rst_lk_addr", lk_addr, 32'h0);
    nRST = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_snoop(vecs[i]);

    // Reset during WB1: word0 already accepted, no state update may follow.
    lk_hit = 1'b1; lk_way = 1'b1; lk_dirty = 1'b1;
    lk_data0 = 32'h7777_0000; lk_data1 = 32'h7777_0001;
    q.push_back('{kind: 0, a: 32'h0000_4008, b: 32'h7777_0000});
    ccwait = 1'b1; ccinv = 1'b0; ccsnoopaddr = 32'h0000_4008; dwait = 1'b1;
    step();
    step();
    ccwait = 1'b0;
    dwait  = 1'b0;
    step();
    dwait = 1'b1;
    chk("wb1_daddr", daddr, 32'h0000_400C);
    #2 nRST = 1'b0;
    #1;
    chk("arst_dwen", 32'(dWEN), 32'd0);
    chk("arst_ccwrite", 32'(ccwrite), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_daddr", daddr, 32'h0);
    chk("arst_dstore", dstore, 32'h0);
    chk("arst_lk_addr", lk_addr, 32'h0);
    chk("arst_st_we", 32'(st_we), 32'd0);
    step();
    step();
    nRST = 1'b1;
    step();
    chk("arst_sb_drained", 32'(q.size()), 32'd0);
    q.delete();
    run_snoop(vecs[2]);
    run_snoop(vecs[1]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/snoop_responder.md
Name: snoop_responder

Overview:
- Cache-side responder of the coherence bus; one instance per dcache.
- Answers snoops raised by the coherency controller (ccwait/ccsnoopaddr/ccinv) using an MSI view of the local dcache frames.
- Reports the snoop outcome on ccwrite. On a Modified hit, drives the 2-word dirty block onto the data bus (dWEN/daddr/dstore).
- Downgrades the frame M->S, or invalidates it, through a single-cycle array update port.

Parameters:
- WAYS, 2, associativity of the attached dcache. WAY_W = $clog2(WAYS), minimum 1.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- ccwait  in  1  controller is snooping this cache; held high until the controller leaves its snoop state
- ccinv  in  1  requestor wants exclusive access; sampled with ccwait
- ccsnoopaddr  in  32  snooped byte address
- dwait  in  1  bus wait for this cache's data port; low = current word accepted
- cache_idle  in  1  local dcache FSM is idle and the arrays are free
- ccwrite  out  1  snoop response valid
- dWEN  out  1  supplying a dirty block (write toward bus)
- daddr  out  32  address of the word being supplied
- dstore  out  32  data of the word being supplied
- busy  out  1  responder owns the arrays; local dcache FSM must stall
- lk_addr  out  32  lookup address presented to tag/state arrays
- lk_hit  in  1  valid tag match at lk_addr (combinational from arrays)
- lk_way  in  WAY_W  matching way
- lk_dirty  in  1  matching frame is Modified
- lk_data0  in  32  block word 0 of matching frame
- lk_data1  in  32  block word 1 of matching frame
- st_we  out  1  single-cycle state update strobe
- st_way  out  WAY_W  way to update
- st_valid  out  1  new valid bit
- st_dirty  out  1  new dirty bit (always 0)

Behaviour:
- Address split: tag | index | block offset [2] | byte offset [1:0]. Block base = {addr[31:3],3'b000}; word1 = base+4.
- Registers: saddr (32), sinv (1), sway, shit, sdirty, sdata0, sdata1. lk_addr = saddr at all times.
- Reset: state IDLE; saddr, sinv and all captured registers 0; every output 0.
- States: IDLE, LOOKUP, WB0, WB1, UPD, RESP.
- IDLE:
  - If ccwait && cache_idle: capture saddr <= ccsnoopaddr and sinv <= ccinv, then go to LOOKUP.
  - If ccwait && !cache_idle: stay in IDLE. The controller holds ccwait, so no request is lost.
- LOOKUP (busy=1):
  - Sample lk_hit, lk_way, lk_dirty, lk_data0 and lk_data1 into the captured registers.
  - If lk_hit && lk_dirty, go to WB0; otherwise go to RESP.
- WB0 (busy=1, ccwrite=1, dWEN=1):
  - daddr = word0 address, dstore = sdata0.
  - Hold until dwait==0, then go to WB1.
- WB1 (busy=1, ccwrite=1, dWEN=1):
  - daddr = word1 address, dstore = sdata1.
  - Hold until dwait==0, then go to UPD.
- UPD (busy=1):
  - st_we=1, st_way=sway, st_dirty=0, st_valid=!sinv (M->S on read snoop, M->I on invalidating snoop).
  - Next state is IDLE.
- RESP (busy=1, ccwrite=1, dWEN=0):
  - On the first RESP cycle only: st_we=1 if shit && sinv, with st_valid=0 and st_way=sway (S->I). Miss, or hit without sinv, produces no update.
  - Hold ccwrite until ccwait==0, then go to IDLE.
- daddr and dstore are 0 whenever dWEN=0. ccwrite and dWEN are never asserted in IDLE, LOOKUP or UPD.
- Latency:
  - Miss or clean hit: ccwrite rises 2 cycles after the ccwait&&cache_idle edge.
  - Dirty hit: dWEN rises 2 cycles after that edge. st_we fires 1 cycle after word1 is accepted.
- Boundaries:
  - dwait is ignored outside WB0/WB1.
  - ccwait dropping during WB0/WB1 does not abort the writeback.
  - ccsnoopaddr and ccinv changes after capture are ignored.
  - Back-to-back snoops: a new capture happens only after returning to IDLE.
  - nRST asserted mid-writeback: immediate IDLE with outputs 0; no partial state update is issued.

Test Plan:
- Miss: ccwait=1, ccinv=0, addr 0x0000_1008, lk_hit=0 -> ccwrite=1 at cycle 2, dWEN=0, st_we never pulses; ccwait=0 -> IDLE and busy=0 next cycle.
- Clean hit with inv: lk_hit=1, lk_dirty=0, lk_way=1, ccinv=1 -> single st_we pulse with st_way=1, st_valid=0, st_dirty=0; ccwrite stays high until ccwait drops.
- Dirty hit, read snoop, addr 0x0000_2044:
  - lk_data0=0xDEAD_BEEF, lk_data1=0xCAFE_F00D, dwait low after 3 and 2 cycles.
  - WB0 drives daddr=0x2040, dstore=0xDEADBEEF; WB1 drives daddr=0x2044, dstore=0xCAFEF00D.
  - Then st_we with st_valid=1, st_dirty=0.
- Dirty hit with ccinv=1 -> same 2-word writeback, then st_we with st_valid=0.
- cache_idle=0 for 4 cycles with ccwait=1 -> busy stays 0 and no capture; capture happens on the cycle cache_idle rises.
- nRST pulse during WB1 -> all outputs 0 asynchronously, no st_we; a subsequent snoop completes normally.
